// File: rtl/freq_pkg.sv
// ----------------------------------------------------------------------------
// freq_pkg
// Shared types and constants for the auto-ranging frequency counter
// sequencer: FSM state encoding, range codes and edge-count thresholds.
// No ports.
// ----------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [1:0] {
        COUNT   = 2'd0,
        EVAL    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    // Range 0 is the longest (most sensitive) window, range 2 the shortest.
    localparam logic [1:0] RANGE_0 = 2'd0;
    localparam logic [1:0] RANGE_1 = 2'd1;
    localparam logic [1:0] RANGE_2 = 2'd2;

    // Edge count saturates one above the largest displayable value so that
    // "overflowed" is distinguishable from a genuine 99.
    localparam logic [6:0] COUNT_SAT       = 7'd100;
    localparam logic [6:0] COUNT_MAX_SHOWN = 7'd99;
    localparam logic [6:0] COUNT_MIN       = 7'd10;

    // Saturating increment of the edge counter.
    function automatic logic [6:0] sat_inc(input logic [6:0] value);
        return (value == COUNT_SAT) ? COUNT_SAT : 7'(value + 7'd1);
    endfunction

endpackage

// File: rtl/freq_range_controller_if.sv
// ----------------------------------------------------------------------------
// freq_range_controller_if
// Valid/ready result channel from the range sequencer to the digit
// conversion path.
//   result_valid  reading available (producer -> consumer)
//   result_ready  consumer accepts the reading (consumer -> producer)
//   result_count  edge count 0..99
//   result_range  range the reading was taken in
//   result_over   reading saturated; result_count forced to 99
// ----------------------------------------------------------------------------
interface freq_range_controller_if;

    logic       result_valid;
    logic       result_ready;
    logic [6:0] result_count;
    logic [1:0] result_range;
    logic       result_over;

    modport master (
        output result_valid,
        output result_count,
        output result_range,
        output result_over,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_count,
        input  result_range,
        input  result_over,
        output result_ready
    );

endinterface

// File: rtl/gate_timer.sv
// ----------------------------------------------------------------------------
// gate_timer
// Window clock counter with a per-range period select. Counts while run is
// high and flags the last cycle of the window; returns to 0 on window end
// and whenever run is low.
//   clk          system clock
//   reset        synchronous active-high reset
//   run          counting window open (FSM in COUNT)
//   range        selects PERIOD_R0/R1/R2
//   window_done  high during the last cycle of the window
// ----------------------------------------------------------------------------
module gate_timer
    import freq_pkg::*;
#(
    parameter int unsigned BITS      = 12,
    parameter int unsigned PERIOD_R0 = 1199,
    parameter int unsigned PERIOD_R1 = 119,
    parameter int unsigned PERIOD_R2 = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] range,
    output logic       window_done
);

    logic [BITS-1:0] r_clk_counter;
    logic [BITS-1:0] w_period;

    // Range 3 never occurs; fall back to the longest window.
    always_comb begin
        w_period = BITS'(PERIOD_R0);
        case (range)
            RANGE_1: w_period = BITS'(PERIOD_R1);
            RANGE_2: w_period = BITS'(PERIOD_R2);
            default: w_period = BITS'(PERIOD_R0);
        endcase
    end

    assign window_done = run && (r_clk_counter == w_period);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_counter <= '0;
        end else if (run && !window_done) begin
            r_clk_counter <= r_clk_counter + 1'b1;
        end else begin
            r_clk_counter <= '0;
        end
    end

endmodule

// File: rtl/freq_range_controller.sv
// ----------------------------------------------------------------------------
// freq_range_controller
// Auto-ranging measurement sequencer. Opens a counting gate, counts edge
// pulses, then either re-ranges (discarding the reading) or presents the
// reading on a valid/ready channel.
//   clk         system clock
//   reset       synchronous active-high reset
//   edge_pulse  one-cycle pulse per leading edge of the measured signal
//   hold        freezes auto-ranging (sampled in EVAL only)
//   gate        high while a counting window is open
//   res         result channel (master side)
// ----------------------------------------------------------------------------
module freq_range_controller
    import freq_pkg::*;
#(
    parameter int unsigned BITS      = 12,
    parameter int unsigned PERIOD_R0 = 1199,
    parameter int unsigned PERIOD_R1 = 119,
    parameter int unsigned PERIOD_R2 = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    edge_pulse,
    input  logic                    hold,
    output logic                    gate,
    freq_range_controller_if.master res
);

    state_e     r_state;
    state_e     w_state_next;
    logic [6:0] r_edge_count;
    logic [6:0] w_edge_next;
    logic [1:0] r_range;
    logic [1:0] w_range_next;
    logic       w_load;
    logic       w_run;
    logic       w_window_done;

    logic [6:0] r_result_count;
    logic [1:0] r_result_range;
    logic       r_result_over;

    assign w_run = (r_state == COUNT);

    gate_timer #(
        .BITS      (BITS),
        .PERIOD_R0 (PERIOD_R0),
        .PERIOD_R1 (PERIOD_R1),
        .PERIOD_R2 (PERIOD_R2)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .run         (w_run),
        .range       (r_range),
        .window_done (w_window_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_edge_next  = r_edge_count;
        w_range_next = r_range;
        w_load       = 1'b0;
        unique case (r_state)
            COUNT: begin
                // The edge in the final window cycle still counts.
                if (edge_pulse) begin
                    w_edge_next = sat_inc(r_edge_count);
                end
                if (w_window_done) begin
                    w_state_next = EVAL;
                end
            end
            EVAL: begin
                w_edge_next = '0;
                if ((r_edge_count == COUNT_SAT) && (r_range < RANGE_2) && !hold) begin
                    w_range_next = 2'(r_range + 2'd1);
                    w_state_next = COUNT;
                end else if ((r_edge_count < COUNT_MIN) && (r_range > RANGE_0) && !hold) begin
                    w_range_next = 2'(r_range - 2'd1);
                    w_state_next = COUNT;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (res.result_ready) begin
                    w_state_next = COUNT;
                end
            end
            default: begin
                w_state_next = COUNT;
                w_edge_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= COUNT;
            r_edge_count   <= '0;
            r_range        <= RANGE_0;
            r_result_count <= '0;
            r_result_range <= RANGE_0;
            r_result_over  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_edge_count <= w_edge_next;
            r_range      <= w_range_next;
            if (w_load) begin
                r_result_count <= (r_edge_count == COUNT_SAT) ? COUNT_MAX_SHOWN : r_edge_count;
                r_result_range <= r_range;
                r_result_over  <= (r_edge_count == COUNT_SAT);
            end
        end
    end

    // Outputs decode registered state only; ready never reaches an output
    // combinationally.
    assign gate             = (r_state == COUNT);
    assign res.result_valid = (r_state == PRESENT);
    assign res.result_count = r_result_count;
    assign res.result_range = r_result_range;
    assign res.result_over  = r_result_over;

endmodule
